// File: rtl/rvx10_pkg.sv
// ---------------------------------------------------------------------------
// rvx10_pkg
// Shared definitions for the RVX10 ID-stage control path: major opcodes,
// ALU operation codes, result/immediate source selectors and the control
// bundle carried from ID into EX.
// ---------------------------------------------------------------------------
package rvx10_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

    // funct7 values used by the base ISA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_ANDN = 5'd10,
        ALU_ORN  = 5'd11,
        ALU_XNOR = 5'd12,
        ALU_MIN  = 5'd13,
        ALU_MAX  = 5'd14,
        ALU_MINU = 5'd15,
        ALU_MAXU = 5'd16,
        ALU_ROL  = 5'd17,
        ALU_ROR  = 5'd18,
        ALU_ABS  = 5'd19
    } alu_op_t;

    // Writeback result source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        alu_op_t    alu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    // Base-ISA funct3 -> ALU op. alt selects SUB/SRA where funct3 allows it.
    function automatic alu_op_t f3_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decoder: turns one instruction word into
// the ID/EX control bundle, an illegal-instruction flag and the source
// register usage flags consumed by the load-use hazard check.
//
// Ports:
//   instr     in   32  instruction word
//   ctrl      out      decoded control bundle (all-zero when illegal)
//   illegal   out  1   opcode or funct combination not supported
//   rs1_used  out  1   instruction reads rs1
//   rs2_used  out  1   instruction reads rs2
// ---------------------------------------------------------------------------
module ctrl_decode
    import rvx10_pkg::*;
#(
    parameter bit ENABLE_RVX10 = 1'b1
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         illegal,
    output logic         rs1_used,
    output logic         rs2_used
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];

        case (opcode)
            OP_LOAD: begin
                // LB, LH, LW, LBU, LHU
                illegal         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_op     = ALU_ADD;
                rs1_used        = 1'b1;
            end
            OP_STORE: begin
                // SB, SH, SW
                illegal         = (f3[2] == 1'b1) || (f3 == 3'b011);
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_S;
                ctrl.alu_op     = ALU_ADD;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_R: begin
                // funct7 alternate encoding only exists for SUB and SRA
                illegal         = !((f7 == F7_BASE) ||
                                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = f3_alu_op(f3, f7[5]);
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_I: begin
                // Only the shift immediates constrain funct7; ADDI has no SUB form
                case (f3)
                    3'b001:  illegal = (f7 != F7_BASE);
                    3'b101:  illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                    default: illegal = 1'b0;
                endcase
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_op     = f3_alu_op(f3, (f3 == 3'b101) && f7[5]);
                rs1_used        = 1'b1;
            end
            OP_BRANCH: begin
                illegal         = (f3 == 3'b010) || (f3 == 3'b011);
                ctrl.branch     = 1'b1;
                ctrl.imm_src    = IMM_B;
                ctrl.alu_op     = ALU_SUB;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_JALR: begin
                illegal         = (f3 != 3'b000);
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_op     = ALU_ADD;
                rs1_used        = 1'b1;
            end
            OP_CUSTOM0: begin
                ctrl.reg_write  = 1'b1;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: ctrl.alu_op = ALU_ANDN;
                    {7'b0000000, 3'b001}: ctrl.alu_op = ALU_ORN;
                    {7'b0000000, 3'b010}: ctrl.alu_op = ALU_XNOR;
                    {7'b0000001, 3'b000}: ctrl.alu_op = ALU_MIN;
                    {7'b0000001, 3'b001}: ctrl.alu_op = ALU_MAX;
                    {7'b0000001, 3'b010}: ctrl.alu_op = ALU_MINU;
                    {7'b0000001, 3'b011}: ctrl.alu_op = ALU_MAXU;
                    {7'b0000010, 3'b000}: ctrl.alu_op = ALU_ROL;
                    {7'b0000010, 3'b001}: ctrl.alu_op = ALU_ROR;
                    {7'b0000011, 3'b000}: ctrl.alu_op = ALU_ABS;
                    default:              illegal     = 1'b1;
                endcase
                if (!ENABLE_RVX10) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        // An illegal instruction must not have any architectural side effect
        // and must not create a hazard, so everything is cleared.
        if (illegal) begin
            ctrl     = '0;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// decode_ctrl_pipe
// ID-stage control unit for the RVX10 pipelined core. Decodes the ID
// instruction, detects load-use hazards against the EX entry, and registers
// the control bundle into ID/EX with flush, hold and bubble handling. Also
// keeps a saturating count of inserted load-use bubbles.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_valid_i          ID holds a valid instruction
//   id_instr_i          instruction word in ID
//   id_ready_o          ID instruction consumed this cycle
//   flush_i             redirect: drop ID instruction and kill EX entry
//   ex_ready_i          EX can accept; low holds ID/EX
//   ex_valid_o          ID/EX entry valid
//   ex_*_o              registered control bundle and register indices
//   ex_illegal_o        entry is an illegal instruction
//   load_use_stall_o    a load-use bubble is inserted this cycle
//   bubble_cnt_o        saturating load-use bubble count
// ---------------------------------------------------------------------------
module decode_ctrl_pipe
    import rvx10_pkg::*;
#(
    parameter bit ENABLE_RVX10    = 1'b1,
    parameter bit LOAD_USE_DETECT = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [31:0]      id_instr_i,
    output logic             id_ready_o,
    input  logic             flush_i,
    input  logic             ex_ready_i,
    output logic             ex_valid_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_write_o,
    output logic             ex_alu_src_o,
    output logic             ex_branch_o,
    output logic             ex_jump_o,
    output logic [1:0]       ex_result_src_o,
    output logic [1:0]       ex_imm_src_o,
    output logic [4:0]       ex_alu_op_o,
    output logic [4:0]       ex_rd_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic             ex_illegal_o,
    output logic             load_use_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    ctrl_bundle_t     dec_ctrl;
    logic             dec_illegal;
    logic             dec_rs1_used;
    logic             dec_rs2_used;

    ctrl_bundle_t     ex_ctrl_p0;
    logic             ex_vld_p0;
    logic             ex_illegal_p0;
    logic [CNT_W-1:0] bubble_cnt_p0;

    logic             ex_is_load;
    logic             rs_match;
    logic             hazard;
    logic             stall;

    ctrl_decode #(
        .ENABLE_RVX10 (ENABLE_RVX10)
    ) u_ctrl_decode (
        .instr    (id_instr_i),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // A load writing x0 never produces a value anyone waits for.
    assign ex_is_load = ex_vld_p0 && (ex_ctrl_p0.result_src == RES_MEM) &&
                        (ex_ctrl_p0.rd != 5'd0);
    assign rs_match   = (dec_rs1_used && (dec_ctrl.rs1 == ex_ctrl_p0.rd)) ||
                        (dec_rs2_used && (dec_ctrl.rs2 == ex_ctrl_p0.rd));
    assign hazard     = LOAD_USE_DETECT && id_valid_i && ex_is_load && rs_match;

    // Flush and a held EX both take precedence, so no bubble is counted then.
    assign stall      = hazard && !reset && !flush_i && ex_ready_i;
    assign id_ready_o = !reset && (flush_i || (ex_ready_i && !stall));
    assign load_use_stall_o = stall;

    // ---- ID/EX register (p0) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_vld_p0     <= 1'b0;
            ex_illegal_p0 <= 1'b0;
            ex_ctrl_p0    <= '0;
            bubble_cnt_p0 <= '0;
        end else if (flush_i) begin
            ex_vld_p0     <= 1'b0;
            ex_illegal_p0 <= 1'b0;
            ex_ctrl_p0    <= '0;
        end else if (!ex_ready_i) begin
            ex_vld_p0     <= ex_vld_p0;
            ex_illegal_p0 <= ex_illegal_p0;
            ex_ctrl_p0    <= ex_ctrl_p0;
        end else if (stall) begin
            ex_vld_p0     <= 1'b0;
            ex_illegal_p0 <= 1'b0;
            ex_ctrl_p0    <= '0;
            bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
        end else begin
            ex_vld_p0     <= id_valid_i;
            ex_illegal_p0 <= id_valid_i && dec_illegal;
            ex_ctrl_p0    <= id_valid_i ? dec_ctrl : '0;
        end
    end

    assign ex_valid_o      = ex_vld_p0;
    assign ex_reg_write_o  = ex_ctrl_p0.reg_write;
    assign ex_mem_write_o  = ex_ctrl_p0.mem_write;
    assign ex_alu_src_o    = ex_ctrl_p0.alu_src;
    assign ex_branch_o     = ex_ctrl_p0.branch;
    assign ex_jump_o       = ex_ctrl_p0.jump;
    assign ex_result_src_o = ex_ctrl_p0.result_src;
    assign ex_imm_src_o    = ex_ctrl_p0.imm_src;
    assign ex_alu_op_o     = ex_ctrl_p0.alu_op;
    assign ex_rd_o         = ex_ctrl_p0.rd;
    assign ex_rs1_o        = ex_ctrl_p0.rs1;
    assign ex_rs2_o        = ex_ctrl_p0.rs2;
    assign ex_illegal_o    = ex_illegal_p0;
    assign bubble_cnt_o    = bubble_cnt_p0;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl_pipe
// Three instances share one stimulus stream: default parameters,
// ENABLE_RVX10=0, and CNT_W=2. A reference model derived from the ISA rules
// produces per-cycle expectations which a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;

    always #5 clk = ~clk;

    // Per-instance outputs
    logic        rdy   [3];
    logic        st    [3];
    logic        vld   [3];
    logic        rw    [3];
    logic        mw    [3];
    logic        asrc  [3];
    logic        br    [3];
    logic        jmp   [3];
    logic [1:0]  rsrc  [3];
    logic [1:0]  isrc  [3];
    logic [4:0]  aop   [3];
    logic [4:0]  rd    [3];
    logic [4:0]  rs1   [3];
    logic [4:0]  rs2   [3];
    logic        ill   [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    decode_ctrl_pipe u_dut0 (
        .clk(clk), .reset(rst), .id_valid_i(id_valid), .id_instr_i(id_instr),
        .id_ready_o(rdy[0]), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(vld[0]), .ex_reg_write_o(rw[0]), .ex_mem_write_o(mw[0]),
        .ex_alu_src_o(asrc[0]), .ex_branch_o(br[0]), .ex_jump_o(jmp[0]),
        .ex_result_src_o(rsrc[0]), .ex_imm_src_o(isrc[0]), .ex_alu_op_o(aop[0]),
        .ex_rd_o(rd[0]), .ex_rs1_o(rs1[0]), .ex_rs2_o(rs2[0]),
        .ex_illegal_o(ill[0]), .load_use_stall_o(st[0]), .bubble_cnt_o(cnt0)
    );

    decode_ctrl_pipe #(.ENABLE_RVX10(1'b0)) u_dut1 (
        .clk(clk), .reset(rst), .id_valid_i(id_valid), .id_instr_i(id_instr),
        .id_ready_o(rdy[1]), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(vld[1]), .ex_reg_write_o(rw[1]), .ex_mem_write_o(mw[1]),
        .ex_alu_src_o(asrc[1]), .ex_branch_o(br[1]), .ex_jump_o(jmp[1]),
        .ex_result_src_o(rsrc[1]), .ex_imm_src_o(isrc[1]), .ex_alu_op_o(aop[1]),
        .ex_rd_o(rd[1]), .ex_rs1_o(rs1[1]), .ex_rs2_o(rs2[1]),
        .ex_illegal_o(ill[1]), .load_use_stall_o(st[1]), .bubble_cnt_o(cnt1)
    );

    decode_ctrl_pipe #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(rst), .id_valid_i(id_valid), .id_instr_i(id_instr),
        .id_ready_o(rdy[2]), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_valid_o(vld[2]), .ex_reg_write_o(rw[2]), .ex_mem_write_o(mw[2]),
        .ex_alu_src_o(asrc[2]), .ex_branch_o(br[2]), .ex_jump_o(jmp[2]),
        .ex_result_src_o(rsrc[2]), .ex_imm_src_o(isrc[2]), .ex_alu_op_o(aop[2]),
        .ex_rd_o(rd[2]), .ex_rs1_o(rs1[2]), .ex_rs2_o(rs2[2]),
        .ex_illegal_o(ill[2]), .load_use_stall_o(st[2]), .bubble_cnt_o(cnt2)
    );

    function automatic logic [30:0] act_bundle(input int i);
        return {vld[i], rw[i], mw[i], asrc[i], br[i], jmp[i], rsrc[i], isrc[i],
                aop[i], rd[i], rs1[i], rs2[i], ill[i]};
    endfunction

    function automatic logic [31:0] act_cnt(input int i);
        case (i)
            0:       return {16'h0, cnt0};
            1:       return {16'h0, cnt1};
            default: return {30'h0, cnt2};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       legal;
        logic       rw, mw, asrc, br, jmp;
        logic [1:0] rsrc, isrc;
        logic [4:0] aop, rd, rs1, rs2;
        logic       use1, use2;
    } dec_t;

    // funct3 -> ALU code for the plain (funct7=0) base operations
    localparam logic [39:0] RTAB = {5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0};
    // CUSTOM-0 {funct7,funct3} list; entry k decodes to ALU code 10+k
    localparam logic [99:0] CTAB = {
        {7'd3, 3'd0}, {7'd2, 3'd1}, {7'd2, 3'd0}, {7'd1, 3'd3}, {7'd1, 3'd2},
        {7'd1, 3'd1}, {7'd1, 3'd0}, {7'd0, 3'd2}, {7'd0, 3'd1}, {7'd0, 3'd0}};

    function automatic dec_t ref_decode(input logic [31:0] ins, input bit en);
        dec_t d;
        logic [6:0] op = ins[6:0];
        logic [6:0] f7 = ins[31:25];
        logic [2:0] f3 = ins[14:12];
        d = '0;
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        case (op)
            7'h03: begin  // loads
                d.legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                d.rw = 1; d.asrc = 1; d.rsrc = 2'd1; d.use1 = 1;
            end
            7'h23: begin  // stores
                d.legal = (f3 <= 2);
                d.mw = 1; d.asrc = 1; d.isrc = 2'd1; d.use1 = 1; d.use2 = 1;
            end
            7'h33: begin  // register-register
                d.rw = 1; d.use1 = 1; d.use2 = 1;
                if (f7 == 0) begin d.legal = 1; d.aop = RTAB[f3*5 +: 5]; end
                else if (f7 == 7'h20 && f3 == 0) begin d.legal = 1; d.aop = 5'd1; end
                else if (f7 == 7'h20 && f3 == 5) begin d.legal = 1; d.aop = 5'd7; end
            end
            7'h13: begin  // register-immediate
                d.rw = 1; d.asrc = 1; d.use1 = 1;
                if (f3 == 1) begin d.legal = (f7 == 0); d.aop = 5'd2; end
                else if (f3 == 5) begin
                    d.legal = (f7 == 0 || f7 == 7'h20);
                    d.aop = (f7 == 7'h20) ? 5'd7 : 5'd6;
                end else begin d.legal = 1; d.aop = RTAB[f3*5 +: 5]; end
            end
            7'h63: begin  // branches
                d.legal = !(f3 == 2 || f3 == 3);
                d.br = 1; d.isrc = 2'd2; d.aop = 5'd1; d.use1 = 1; d.use2 = 1;
            end
            7'h6f: begin  // JAL
                d.legal = 1; d.rw = 1; d.jmp = 1; d.rsrc = 2'd2; d.isrc = 2'd3;
            end
            7'h67: begin  // JALR
                d.legal = (f3 == 0);
                d.rw = 1; d.jmp = 1; d.asrc = 1; d.rsrc = 2'd2; d.use1 = 1;
            end
            7'h0b: begin  // CUSTOM-0
                d.rw = 1; d.use1 = 1; d.use2 = 1;
                for (int k = 0; k < 10; k++) begin
                    if (CTAB[k*10 +: 10] == {f7, f3}) begin
                        d.legal = en; d.aop = 5'(10 + k);
                    end
                end
            end
            default: d.legal = 0;
        endcase
        if (!d.legal) d = '0;
        return d;
    endfunction

    // Model state per instance
    bit          m_en  [3] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_max [3] = '{65535, 65535, 3};
    bit          m_valid [3];
    bit          m_ill   [3];
    dec_t        m_d     [3];
    int unsigned m_cnt   [3];
    bit          last_rdy0;

    typedef struct packed {
        logic [2:0][30:0] b;
        logic [2:0]       rdy;
        logic [2:0]       st;
        logic [2:0][31:0] cnt;
    } rec_t;

    rec_t exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the expected view of this cycle is queued
    // and the model is advanced past the next rising edge.
    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input bit f, input bit ry);
        rec_t e;
        dec_t d;
        bit   hz, stl, rd_y;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_instr = ins; flush = f; ex_ready = ry;
        for (int i = 0; i < 3; i++) begin
            d    = ref_decode(ins, m_en[i]);
            hz   = m_valid[i] && m_d[i].rsrc == 2'd1 && m_d[i].rd != 0 && v &&
                   ((d.use1 && d.rs1 == m_d[i].rd) || (d.use2 && d.rs2 == m_d[i].rd));
            stl  = !r && !f && ry && hz;
            rd_y = !r && (f || (ry && !stl));
            e.b[i]   = {m_valid[i], m_d[i].rw, m_d[i].mw, m_d[i].asrc, m_d[i].br,
                        m_d[i].jmp, m_d[i].rsrc, m_d[i].isrc, m_d[i].aop,
                        m_d[i].rd, m_d[i].rs1, m_d[i].rs2, m_ill[i]};
            e.rdy[i] = rd_y;
            e.st[i]  = stl;
            e.cnt[i] = m_cnt[i];
            if (r) begin
                m_valid[i] = 0; m_ill[i] = 0; m_d[i] = '0; m_cnt[i] = 0;
            end else if (f || (ry && stl)) begin
                m_valid[i] = 0; m_ill[i] = 0; m_d[i] = '0;
                if (stl && m_cnt[i] < m_max[i]) m_cnt[i]++;
            end else if (ry) begin
                m_valid[i] = v;
                m_ill[i]   = v && !d.legal;
                m_d[i]     = v ? d : '0;
            end
        end
        last_rdy0 = e.rdy[0];
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the DUTs present against the queued view.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk("ex_bundle", i, {1'b0, act_bundle(i)}, {1'b0, e.b[i]});
                    chk("id_ready", i, {31'h0, rdy[i]}, {31'h0, e.rdy[i]});
                    chk("load_use_stall", i, {31'h0, st[i]}, {31'h0, e.st[i]});
                    chk("bubble_cnt", i, act_cnt(i), e.cnt[i]);
                end
            end
        end
    end

    // Instruction builders
    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
        return {f7, s2, s1, f3, d, op};
    endfunction

    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] prog_q [$];

    // Feeds prog_q in order, holding an instruction until it is consumed.
    task automatic run_prog();
        int n = 0;
        while (prog_q.size() > 0 && n < 200) begin
            step(0, 1, prog_q[0], 0, 1);
            if (last_rdy0) void'(prog_q.pop_front());
            n++;
        end
        if (prog_q.size() > 0) begin
            errors++;
            $display("FAIL run_prog: %0d instructions never consumed", prog_q.size());
            prog_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] d  = 5'($urandom_range(0, 3));
        logic [4:0] a  = 5'($urandom_range(0, 3));
        logic [4:0] b  = 5'($urandom_range(0, 3));
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [6:0] f7;
        int sel = $urandom_range(0, 2);
        f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
        case ($urandom_range(0, 9))
            0:       return enc(7'($urandom), b, a, f3, d, 7'h03);
            1:       return enc(7'($urandom), b, a, f3, d, 7'h23);
            2:       return enc(f7, b, a, f3, d, 7'h33);
            3:       return enc(f7, b, a, f3, d, 7'h13);
            4:       return enc(7'($urandom), b, a, f3, d, 7'h63);
            5:       return enc(7'($urandom), b, a, f3, d, 7'h6f);
            6:       return enc(7'($urandom), b, a, ($urandom_range(0, 1) != 0) ? 3'd0 : f3, d, 7'h67);
            7, 8:    return enc(7'($urandom_range(0, 4)), b, a, 3'($urandom_range(0, 4)), d, 7'h0b);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] lw5, add657, cur;
        bit          cur_v;
        lw5    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03);
        add657 = enc(7'h00, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33);

        // Initial reset without checking (state is unknown before it).
        repeat (2) @(posedge clk);

        // Load-use: lw x5 then add x6,x5,x7
        step(1, 0, 32'h0, 0, 1);
        prog_q = '{lw5, add657, NOP};
        run_prog();
        step(0, 0, 32'h0, 0, 1);
        @(negedge clk); #1;
        chk("cnt_after_one_bubble", 0, {16'h0, cnt0}, 32'd1);

        // Load x0 then add x6,x0,x7; load x5 then JAL with rs1 field = 5
        prog_q = '{enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03),
                   enc(7'h00, 5'd7, 5'd0, 3'd0, 5'd6, 7'h33),
                   lw5,
                   enc(7'h00, 5'd0, 5'd5, 3'd0, 5'd1, 7'h6f),
                   enc(7'h01, 5'd2, 5'd1, 3'd3, 5'd3, 7'h0b),  // MAXU x3,x1,x2
                   NOP};
        run_prog();

        // Flush while EX held and a load-use condition present
        step(0, 1, lw5, 0, 1);
        step(0, 1, add657, 1, 0);
        step(0, 0, 32'h0, 0, 1);

        // Store held in EX for three cycles
        step(0, 1, enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23), 0, 1);
        repeat (3) step(0, 1, enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 0, 0);
        step(0, 1, enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 0, 1);
        step(0, 0, 32'h0, 0, 1);

        // Five load-use pairs: the 2-bit counter saturates at 3
        step(1, 0, 32'h0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            prog_q.push_back(lw5);
            prog_q.push_back(add657);
        end
        run_prog();
        step(0, 0, 32'h0, 0, 1);
        @(negedge clk); #1;
        chk("cnt2_saturated", 2, {30'h0, cnt2}, 32'd3);
        chk("cnt0_five", 0, {16'h0, cnt0}, 32'd5);

        // Reset asserted in the middle of a stall
        step(0, 1, lw5, 0, 1);
        step(0, 1, add657, 0, 1);
        step(1, 1, add657, 0, 1);
        step(0, 0, 32'h0, 0, 1);

        // Randomized traffic
        cur = rand_instr(); cur_v = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (last_rdy0 || !cur_v) begin
                cur   = rand_instr();
                cur_v = ($urandom_range(0, 9) < 8);
            end
            step(($urandom_range(0, 199) == 0), cur_v, cur,
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 85));
        end
        step(0, 0, 32'h0, 0, 1);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
